// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: one memory port shared by the pipeline data lane
// and an external loader/debug master, with starvation relief for EXT.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_adr,
    input  logic [31:0] ext_wdata,
    output logic        ext_gnt,
    output logic        ext_done,
    output logic [31:0] ext_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        CPU_BUSY,
        EXT_BUSY
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t     state;
    logic [7:0] starve_cnt;
    logic       cpu_acc;
    logic       ext_win;
    logic       cpu_win;

    assign cpu_acc = cpu_read | cpu_write;

    // EXT only beats a pending CPU access once it has waited long enough
    assign ext_win = (state == IDLE) && ext_req &&
                     (!cpu_acc || (starve_cnt >= LIMIT));
    assign cpu_win = (state == IDLE) && !ext_win && cpu_acc;

    assign cpu_stall = !rst && cpu_acc &&
                       !((state == CPU_BUSY) && mem_ack);
    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_adr    <= '0;
            mem_wdata  <= '0;
            ext_gnt    <= 1'b0;
            ext_done   <= 1'b0;
            ext_rdata  <= '0;
        end else begin
            ext_gnt  <= 1'b0;
            ext_done <= 1'b0;

            if (!ext_req || ext_win || ext_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end

            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        ext_win: begin
                            state     <= EXT_BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= ext_we;
                            mem_adr   <= ext_adr;
                            mem_wdata <= ext_wdata;
                            ext_gnt   <= 1'b1;
                        end
                        cpu_win: begin
                            state     <= CPU_BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= cpu_write;
                            mem_adr   <= cpu_adr;
                            mem_wdata <= cpu_wdata;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
                CPU_BUSY: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                EXT_BUSY: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        ext_done  <= 1'b1;
                        ext_rdata <= mem_rdata;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected
// memory/CPU/EXT completions, a negedge monitor pops and compares them.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
    } mem_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req, ext_we;
    logic [31:0] ext_adr, ext_wdata, ext_rdata;
    logic        ext_gnt, ext_done;
    logic        mem_req, mem_we;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;
    int ack_dly = 0;
    bit spurious = 1'b0;
    int gnt_n = 0;
    int gnt_exp = 0;

    mem_t        mem_q[$];
    logic [31:0] cpu_q[$];
    logic [31:0] ext_q[$];

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we),
        .ext_adr(ext_adr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_rdata(ext_rdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h11);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_adr"}, mem_adr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_ext_gnt"}, ext_gnt, 0);
        chk({tag, "_ext_done"}, ext_done, 0);
        chk({tag, "_ext_rdata"}, ext_rdata, 0);
        chk({tag, "_cpu_stall"}, cpu_stall, 0);
    endtask

    // Memory: ack after ack_dly extra cycles of mem_req, optional spurious ack
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req) begin
                mem_ack = (cnt == ack_dly);
                mem_rdata = rdata_of(mem_adr);
                cnt = mem_ack ? 0 : cnt + 1;
            end else begin
                cnt = 0;
                mem_ack = spurious;
                mem_rdata = 32'h0BAD_0BAD;
            end
        end
    end

    // Monitor
    initial begin
        mem_t        e;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_req && mem_ack) begin
                    if (mem_q.size() == 0) begin
                        chk("mem_unexpected_ack_adr", mem_adr, 32'hFFFF_FFFF);
                    end else begin
                        e = mem_q.pop_front();
                        chk("mem_we", mem_we, e.we);
                        chk("mem_adr", mem_adr, e.adr);
                        chk("mem_wdata", mem_wdata, e.wdata);
                    end
                end
                if ((cpu_read | cpu_write) && !cpu_stall) begin
                    if (cpu_q.size() == 0) begin
                        chk("cpu_unexpected_done", cpu_stall, 1);
                    end else begin
                        r = cpu_q.pop_front();
                        chk("cpu_rdata", cpu_rdata, r);
                    end
                end
                if (ext_done) begin
                    if (ext_q.size() == 0) begin
                        chk("ext_unexpected_done", ext_done, 0);
                    end else begin
                        r = ext_q.pop_front();
                        chk("ext_rdata", ext_rdata, r);
                    end
                end
                if (ext_gnt) gnt_n++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cpu_access(input logic rd, input logic wr,
                              input logic [31:0] adr, input logic [31:0] wd,
                              input int dly);
        int n;
        bit done;
        @(posedge clk);
        #1;
        ack_dly = dly;
        cpu_read = rd;
        cpu_write = wr;
        cpu_adr = adr;
        cpu_wdata = wd;
        mem_q.push_back('{we: wr, adr: adr, wdata: wd});
        cpu_q.push_back(rdata_of(adr));
        n = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1;
            else n++;
        end
        chk("cpu_done", done, 1);
        chk("cpu_stall_cycles", n, dly + 1);
        @(posedge clk);
        #1;
        cpu_read = 0;
        cpu_write = 0;
    endtask

    task automatic wait_gnt(output bit seen, output int cpu_n);
        seen = 0;
        cpu_n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ext_gnt) seen = 1;
            else if ((cpu_read | cpu_write) && !cpu_stall) cpu_n++;
        end
        chk("ext_gnt_seen", seen, 1);
    endtask

    initial begin
        bit seen;
        bit done;
        int n;

        rst = 1; cpu_read = 1; cpu_write = 0;
        cpu_adr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_adr = 0; ext_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk);
        #1;
        rst = 0;
        cpu_read = 0;
        repeat (2) @(posedge clk);

        // CPU load, ack three cycles after mem_req
        cpu_access(1, 0, 32'h40, 32'h0, 3);

        // EXT write while CPU idle
        @(posedge clk);
        #1;
        ack_dly = 0;
        ext_req = 1; ext_we = 1;
        ext_adr = 32'h100; ext_wdata = 32'h12345678;
        mem_q.push_back('{we: 1'b1, adr: 32'h100, wdata: 32'h12345678});
        ext_q.push_back(rdata_of(32'h100));
        gnt_exp++;
        wait_gnt(seen, n);
        chk("ext_gnt_mem_req", mem_req, 1);
        chk("ext_gnt_mem_we", mem_we, 1);
        chk("ext_gnt_mem_adr", mem_adr, 32'h100);
        @(posedge clk);
        #1;
        ext_req = 0;
        repeat (3) @(posedge clk);

        // Store wins when read and write are both requested
        cpu_access(1, 1, 32'h8, 32'hCAFEF00D, 1);

        // Starvation: continuous CPU loads, EXT held
        @(posedge clk);
        #1;
        ack_dly = 0;
        cpu_read = 1; cpu_write = 0;
        cpu_adr = 32'h200; cpu_wdata = 0;
        ext_req = 1; ext_we = 1;
        ext_adr = 32'h300; ext_wdata = 32'hA5A50001;
        mem_q.push_back('{we: 1'b0, adr: 32'h200, wdata: 32'h0});
        mem_q.push_back('{we: 1'b0, adr: 32'h200, wdata: 32'h0});
        mem_q.push_back('{we: 1'b1, adr: 32'h300, wdata: 32'hA5A50001});
        mem_q.push_back('{we: 1'b0, adr: 32'h200, wdata: 32'h0});
        repeat (3) cpu_q.push_back(rdata_of(32'h200));
        ext_q.push_back(rdata_of(32'h300));
        gnt_exp++;
        wait_gnt(seen, n);
        chk("starve_cpu_before_ext", n, 2);
        chk("starve_cpu_stalled", cpu_stall, 1);
        @(posedge clk);
        #1;
        ext_req = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1;
        end
        chk("starve_cpu_resumes", done, 1);
        @(posedge clk);
        #1;
        cpu_read = 0;
        repeat (2) @(posedge clk);

        // Spurious ack while idle
        @(posedge clk);
        #1;
        spurious = 1;
        repeat (2) begin
            @(negedge clk);
            chk("spur_mem_req", mem_req, 0);
            chk("spur_ext_gnt", ext_gnt, 0);
            chk("spur_ext_done", ext_done, 0);
            chk("spur_cpu_stall", cpu_stall, 0);
        end
        @(posedge clk);
        #1;
        spurious = 0;
        cpu_access(1, 0, 32'h44, 32'h0, 2);

        // Reset during EXT_BUSY abandons the access
        @(posedge clk);
        #1;
        ack_dly = 5;
        ext_req = 1; ext_we = 0;
        ext_adr = 32'h180; ext_wdata = 32'h0;
        gnt_exp++;
        wait_gnt(seen, n);
        @(posedge clk);
        #1;
        rst = 1;
        ext_req = 0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk_reset_vals("postrst");
        cpu_access(0, 1, 32'h20, 32'h00C0FFEE, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mem_q_empty", mem_q.size(), 0);
        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("ext_q_empty", ext_q.size(), 0);
        chk("ext_gnt_count", gnt_n, gnt_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles an ungranted ext_req may wait before it overrides a CPU request.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cpu_read  input  1  pipeline lane-2 data load request.
REQ-005 SHALL have port cpu_write  input  1  pipeline lane-2 data store request.
REQ-006 SHALL have port cpu_adr  input  32  pipeline data address.
REQ-007 SHALL have port cpu_wdata  input  32  pipeline store data.
REQ-008 SHALL have port cpu_rdata  output  32  load data returned to the pipeline.
REQ-009 SHALL have port cpu_stall  output  1  freezes the pipeline while its access is pending.
REQ-010 SHALL have port ext_req  input  1  external (loader/debug) access request, held until ext_gnt.
REQ-011 SHALL have port ext_we  input  1  external write enable.
REQ-012 SHALL have port ext_adr  input  32  external address.
REQ-013 SHALL have port ext_wdata  input  32  external write data.
REQ-014 SHALL have port ext_gnt  output  1  one-cycle pulse: external request accepted.
REQ-015 SHALL have port ext_done  output  1  one-cycle pulse: external access complete.
REQ-016 SHALL have port ext_rdata  output  32  registered external read data.
REQ-017 SHALL have port mem_req  output  1  registered memory request, held until mem_ack.
REQ-018 SHALL have port mem_we  output  1  memory write enable.
REQ-019 SHALL have ports mem_adr and mem_wdata  output  32 each  registered memory address and write data.
REQ-020 SHALL have port mem_rdata  input  32  memory read data, valid in the mem_ack cycle.
REQ-021 SHALL have port mem_ack  input  1  memory completion; only meaningful while mem_req=1.

Function
REQ-022 SHALL implement FSM states IDLE, CPU_BUSY and EXT_BUSY.
REQ-023 SHALL treat cpu_acc = cpu_read|cpu_write as the CPU request; when both are high, SHALL perform a write.
REQ-024 In IDLE, SHALL grant EXT if ext_req and (!cpu_acc or starve_cnt >= STARVE_LIMIT); else SHALL grant CPU if cpu_acc; else SHALL stay in IDLE.
REQ-025 On grant, SHALL latch the winner's adr/wdata/we into mem_* registers and set mem_req=1 in the following cycle (one-cycle grant latency).
REQ-026 SHALL keep mem_req and the mem_* registers stable until the cycle mem_ack=1; SHALL return to IDLE on the next edge, with mem_req=0 there.
REQ-027 SHALL drive cpu_stall = cpu_acc & !(state==CPU_BUSY & mem_ack), combinationally.
REQ-028 SHALL pass cpu_rdata = mem_rdata combinationally, so the pipeline captures load data in the ack cycle.
REQ-029 SHALL pulse ext_gnt in the IDLE->EXT_BUSY transition cycle; SHALL pulse ext_done and register ext_rdata=mem_rdata on the EXT_BUSY ack edge.
REQ-030 SHALL have starve_cnt increment (saturating at 255) each cycle ext_req=1 and ext_gnt=0, and clear on ext_gnt or when ext_req=0.
REQ-031 SHALL ignore mem_ack in IDLE; SHALL ignore ext_req and cpu changes while a transaction is busy.
REQ-032 Minimum transaction: grant edge, mem_req cycle with same-cycle ack, then IDLE = 2 cycles; back-to-back CPU accesses SHALL insert one IDLE cycle between them.

Reset
REQ-033 While rst=1, SHALL set state=IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_adr=0, mem_wdata=0, ext_gnt=0, ext_done=0, ext_rdata=0, and force cpu_stall=0.
REQ-034 Reset mid-transaction SHALL abandon the access (mem_req=0 next edge) with no ext_done pulse.

Verification
REQ-035 CPU load adr=0x40, memory acks 3 cycles after mem_req -> cpu_stall high for 4 cycles, cpu_rdata=mem_rdata=0xDEADBEEF in the ack cycle, then stall=0.
REQ-036 ext_req write adr=0x100 data=0x12345678 while CPU idle -> ext_gnt pulse, mem_we=1 mem_adr=0x100, ext_done pulse on the ack edge.
REQ-037 Continuous CPU loads with ext_req held, STARVE_LIMIT=4 -> EXT granted at the first IDLE with starve_cnt>=4; CPU stalls until EXT completes.
REQ-038 cpu_read=cpu_write=1, adr=0x8 -> mem_we=1 write with cpu_wdata.
REQ-039 rst asserted during EXT_BUSY before ack -> mem_req=0 next cycle, no ext_done, state IDLE, all outputs at reset values.
REQ-040 Spurious mem_ack in IDLE -> no state change, no pulses.
